// File: rtl/ps2_keyboard_if.sv
// ps2_keyboard_if: scan-code handshake between the PS/2 receiver and its consumer.
//   read       : consumer acknowledge, one cycle is enough
//   scan_ready : a completed, unread scan code is held
//   scan_code  : last valid received byte
// master = receiver (drives code/ready), slave = consumer (drives read).
interface ps2_keyboard_if;
    logic       read;
    logic       scan_ready;
    logic [7:0] scan_code;

    modport master (
        input  read,
        output scan_ready,
        output scan_code
    );

    modport slave (
        output read,
        input  scan_ready,
        input  scan_code
    );
endinterface

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 device-to-host receiver with a two-digit hex display of the scan code.
//   clock50       : 50 MHz system clock, all state on the rising edge
//   reset         : synchronous, active-high
//   keyboard_clk  : PS/2 clock pin (asynchronous)
//   keyboard_data : PS/2 data pin (asynchronous)
//   bus           : read / scan_ready / scan_code handshake (master side)
//   hex0, hex1    : active-low {g,f,e,d,c,b,a} for scan_code[3:0] and scan_code[7:4]
module ps2_keyboard #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic               clock50,
    input  logic               reset,
    input  logic               keyboard_clk,
    input  logic               keyboard_data,
    ps2_keyboard_if.master     bus,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // Index 0 = PS/2 clock, index 1 = PS/2 data.
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    filt_q, filt_d;
    logic [FW-1:0] fcnt_q [2];
    logic [FW-1:0] fcnt_d [2];
    logic          fall_q, fall_d;

    state_e        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]    code_q, code_d;
    logic          ready_q, ready_d;

    logic          data_bit;
    logic          timed_out;
    logic          start_en, shift_en, parity_en, frame_valid;

    assign data_bit  = filt_q[1];
    assign timed_out = (state_q != StIdle) && (tmo_cnt_q >= TW'(TIMEOUT_CYCLES));

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchroniser then a FILTER_LEN-sample glitch filter.
    // ------------------------------------------------------------------
    always_comb begin
        filt_d = filt_q;
        fall_d = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fcnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end
        end
        // Strobe is registered, so it is seen by the FSM one cycle after the level flips.
        fall_d = filt_q[0] & ~filt_d[0];
    end

    always_ff @(posedge clock50) begin
        if (reset) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            filt_q    <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
            fall_q    <= 1'b0;
        end else begin
            sync1_q   <= {keyboard_data, keyboard_clk};
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            fcnt_q[0] <= fcnt_d[0];
            fcnt_q[1] <= fcnt_d[1];
            fall_q    <= fall_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: state register / next state / outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clock50) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timed_out) begin
            state_d = StIdle;
        end else if (fall_q) begin
            unique case (state_q)
                StIdle:   if (!data_bit) state_d = StData;
                StData:   if (bit_cnt_q == 3'd7) state_d = StParity;
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        start_en    = 1'b0;
        shift_en    = 1'b0;
        parity_en   = 1'b0;
        frame_valid = 1'b0;
        if (fall_q && !timed_out) begin
            unique case (state_q)
                StIdle:   start_en  = ~data_bit;
                StData:   shift_en  = 1'b1;
                StParity: parity_en = 1'b1;
                // Odd parity over data + parity bit, and stop bit must be 1.
                StStop:   frame_valid = data_bit & (^{shift_q, parity_q});
                default:  ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath and handshake.
    // ------------------------------------------------------------------
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        code_d    = code_q;
        ready_d   = ready_q;

        if (start_en) begin
            bit_cnt_d = 3'd0;
        end
        if (shift_en) begin
            shift_d   = {data_bit, shift_q[7:1]};  // LSB first
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (parity_en) begin
            parity_d = data_bit;
        end

        // A completion beats a simultaneous read.
        if (frame_valid) begin
            code_d  = shift_q;
            ready_d = 1'b1;
        end else if (bus.read) begin
            ready_d = 1'b0;
        end

        // Counter only runs inside a frame; any fall restarts it.
        if (fall_q || state_q == StIdle) begin
            tmo_cnt_d = '0;
        end else if (timed_out) begin
            tmo_cnt_d = tmo_cnt_q;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock50) begin
        if (reset) begin
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            parity_q  <= 1'b0;
            tmo_cnt_q <= '0;
            code_q    <= 8'h00;
            ready_q   <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tmo_cnt_q <= tmo_cnt_d;
            code_q    <= code_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.scan_code  = code_q;
    assign bus.scan_ready = ready_q;

    // ------------------------------------------------------------------
    // Hex digit decode, active-low {g,f,e,d,c,b,a}.
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        hex0 = seg7(code_q[3:0]);
        hex1 = seg7(code_q[7:4]);
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard. Uses a short PS/2 half-period and a short timeout so the
// whole run stays small; the filter length is the default.
module tb_ps2_keyboard;

    localparam int FILT = 8;
    localparam int TMO  = 1000;
    localparam int HALF = 40;

    logic       clock50 = 1'b0;
    logic       reset   = 1'b1;
    logic       kb_clk  = 1'b1;
    logic       kb_data = 1'b1;
    logic [6:0] hex0, hex1;

    int n_tests = 0;
    int n_fail  = 0;

    ps2_keyboard_if kb_if ();

    ps2_keyboard #(
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock50       (clock50),
        .reset         (reset),
        .keyboard_clk  (kb_clk),
        .keyboard_data (kb_data),
        .bus           (kb_if.master),
        .hex0          (hex0),
        .hex1          (hex1)
    );

    always #10 clock50 = ~clock50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock50);
    endtask

    // mode: 0 plain, 1 check ready latency on stop fall, 2 read pulse at completion edge,
    //       3 3-cycle clock glitch inside the high half of bit 4.
    task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic stop_bit,
                              input int mode);
        logic [10:0] bits;
        bits = {stop_bit, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < 11; i++) begin
            kb_data = bits[i];
            cycles(HALF / 2);
            if (mode == 3 && i == 4) begin
                kb_clk = 1'b0;
                cycles(3);
                kb_clk = 1'b1;
            end
            cycles(HALF / 2);
            kb_clk = 1'b0;
            if (i == 10 && mode == 1) begin
                cycles(FILT + 2);
                check("ready_before_latency", kb_if.scan_ready, 1'b0);
                cycles(1);
                check("ready_at_latency", kb_if.scan_ready, 1'b1);
                cycles(HALF - FILT - 3);
            end else if (i == 10 && mode == 2) begin
                cycles(FILT + 2);
                kb_if.read = 1'b1;
                cycles(1);
                kb_if.read = 1'b0;
                cycles(HALF - FILT - 3);
            end else begin
                cycles(HALF);
            end
            kb_clk = 1'b1;
        end
        kb_data = 1'b1;
        cycles(HALF);
    endtask

    task automatic send_partial(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            kb_data = (i == 0) ? 1'b0 : 1'b1;
            cycles(HALF);
            kb_clk = 1'b0;
            cycles(HALF);
            kb_clk = 1'b1;
        end
        kb_data = 1'b1;
    endtask

    initial begin
        kb_if.read = 1'b0;
        cycles(5);
        reset = 1'b0;
        cycles(20);

        check("rst_ready", kb_if.scan_ready, 1'b0);
        check("rst_code", kb_if.scan_code, 8'h00);
        check("rst_hex0", hex0, 7'b1000000);
        check("rst_hex1", hex1, 7'b1000000);

        // Idle glitch that looks like a start bit if it were accepted.
        kb_data = 1'b0;
        cycles(5);
        kb_clk = 1'b0;
        cycles(3);
        kb_clk = 1'b1;
        cycles(5);
        kb_data = 1'b1;
        cycles(30);

        send_frame(8'h1C, 1'b0, 1'b1, 1);
        check("f1c_code", kb_if.scan_code, 8'h1C);
        check("f1c_ready", kb_if.scan_ready, 1'b1);
        check("f1c_hex0", hex0, 7'b1000110);
        check("f1c_hex1", hex1, 7'b1111001);

        kb_if.read = 1'b1;
        cycles(1);
        kb_if.read = 1'b0;
        check("read_clears", kb_if.scan_ready, 1'b0);
        check("read_keeps_code", kb_if.scan_code, 8'h1C);

        send_frame(8'h32, 1'b1, 1'b1, 0);
        check("badpar_ready", kb_if.scan_ready, 1'b0);
        check("badpar_code", kb_if.scan_code, 8'h1C);
        send_frame(8'h32, 1'b0, 1'b0, 0);
        check("badstop_ready", kb_if.scan_ready, 1'b0);
        check("badstop_code", kb_if.scan_code, 8'h1C);

        send_partial(5);
        cycles(TMO + 500);
        send_frame(8'h21, 1'b0, 1'b1, 0);
        check("tmo_code", kb_if.scan_code, 8'h21);
        check("tmo_ready", kb_if.scan_ready, 1'b1);
        check("f21_hex0", hex0, 7'b1111001);
        check("f21_hex1", hex1, 7'b0100100);

        send_frame(8'h1C, 1'b0, 1'b1, 0);
        send_frame(8'h23, 1'b0, 1'b1, 0);
        check("overwrite_code", kb_if.scan_code, 8'h23);
        check("overwrite_ready", kb_if.scan_ready, 1'b1);

        send_frame(8'h24, 1'b0, 1'b1, 2);
        check("race_ready", kb_if.scan_ready, 1'b1);
        check("race_code", kb_if.scan_code, 8'h24);

        send_frame(8'h3B, 1'b0, 1'b1, 3);
        check("glitch_code", kb_if.scan_code, 8'h3B);
        check("glitch_hex0", hex0, 7'b0000011);
        check("glitch_hex1", hex1, 7'b0110000);

        send_partial(5);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check("midrst_ready", kb_if.scan_ready, 1'b0);
        check("midrst_code", kb_if.scan_code, 8'h00);
        check("midrst_hex0", hex0, 7'b1000000);
        cycles(5);
        send_frame(8'h1A, 1'b0, 1'b1, 0);
        check("f1a_code", kb_if.scan_code, 8'h1A);
        check("f1a_ready", kb_if.scan_ready, 1'b1);
        check("f1a_hex0", hex0, 7'b0001000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

PS/2 keyboard receiver with scan-code hex display. It deserialises device-to-host PS/2 frames into 8-bit scan codes and holds each code with a ready/read handshake. It also drives two active-low seven-segment digits with the current code. It sits between the board PS/2 pins and the keyboard-to-letter decoder that feeds the rotor/reflector path and the VGA gui.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before a PS/2 line level is accepted.
- TIMEOUT_CYCLES, 50000: clock50 cycles without a filtered falling edge that abort a partial frame (1 ms at 50 MHz).

Ports:
- clock50, input, 1: system clock, 50 MHz. All state updates on rising edge.
- reset, input, 1: synchronous, active-high.
- keyboard_clk, input, 1: PS/2 clock pin, asynchronous.
- keyboard_data, input, 1: PS/2 data pin, asynchronous.
- read, input, 1: consumer acknowledge, sampled each cycle.
- scan_ready, output, 1: a completed, unread scan code is held.
- scan_code, output, 8: last valid received byte.
- hex0, output, 7: active-low segments {g,f,e,d,c,b,a} for scan_code[3:0].
- hex1, output, 7: same encoding, for scan_code[7:4].

## Operation
- Input conditioning:
  - Each pin passes through a 2-FF synchroniser, then a glitch filter.
  - The filtered level changes only after FILTER_LEN consecutive equal samples.
  - A falling edge of the filtered clock is a one-cycle "fall" strobe.
- Frame format (11 bits, data sampled on each fall):
  - start bit = 0;
  - 8 data bits, LSB first;
  - odd parity bit (data ones + parity = odd);
  - stop bit = 1.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0, clear bit counter and go to DATA. A fall with data=1 is ignored.
  - DATA: shift in a bit on each fall; after the 8th bit go to PARITY.
  - PARITY: store the parity bit and go to STOP.
  - STOP: on fall, the frame is valid if parity is correct and stop=1. Either way, return to IDLE.
- Valid frame: scan_code <= byte and scan_ready <= 1 on the same clock edge.
- Invalid frame: discarded; scan_code and scan_ready are unchanged.
- Timeout: a cycle counter resets on every fall. If it reaches TIMEOUT_CYCLES while not in IDLE, the FSM returns to IDLE and the partial frame is discarded.
- Handshake:
  - scan_ready stays high until read=1 is sampled, then clears on that edge.
  - A new valid frame arriving while scan_ready=1 overwrites scan_code (latest wins); scan_ready stays 1.
  - A valid completion in the same cycle as read=1: completion wins, so scan_ready stays 1 with the new code.
- Hex decode (combinational from scan_code), active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- No transmit (host-to-device) support. Both lines are inputs only.

## Timing
- Reset values:
  - scan_code=8'h00, scan_ready=0;
  - hex0=hex1=7'b1000000;
  - FSM=IDLE, counters cleared;
  - synchroniser and filter outputs=1 (idle bus).
- Reset mid-frame aborts the frame with no output change other than the reset values above.
- Pin-to-fall latency: 2 synchroniser cycles + FILTER_LEN filter cycles.
- scan_ready rises on the fall-strobe edge of the stop bit, i.e. 2+FILTER_LEN+1 cycles after the 11th pin falling edge.
- scan_ready falls one edge after read is sampled high. read may be a single-cycle pulse.
- hex outputs follow scan_code combinationally, with zero added latency.
- Pulses shorter than FILTER_LEN cycles on either pin are rejected.

## Test plan
- Reset, then idle lines high → scan_ready=0, scan_code=00, hex0=hex1=1000000.
- Valid frame with 20 µs PS/2 half-periods for code 0x1C (parity=0) → scan_code=1C, scan_ready=1, hex0=1000110 ('C'), hex1=1111001 ('1'). Pulse read for one cycle → scan_ready=0 on the next edge; code retained.
- Frame 0x32 with parity=1 (bad) → scan_ready stays 0, scan_code unchanged. Frame 0x32 with stop=0 → same result.
- Five bits of a frame, then lines idle for 60000 cycles, then a valid frame 0x21 → scan_code=21, scan_ready=1.
- Frame 0x1C, no read, then frame 0x23 → scan_code=23, scan_ready=1. A read pulse coinciding with the completion of a third frame 0x24 → scan_ready=1, scan_code=24.
- 3-cycle low glitches on keyboard_clk during idle and mid-frame → ignored. Reset asserted mid-frame, then a valid frame 0x1A → scan_code=1A, scan_ready=1.
